lapido_mem_arbiter: RTL and testbench

Arbitrates between the instruction-fetch port (IF stage) and the data-memory port (MEM stage) for one shared single-port unified memory with variable latency. The arbiter grants one requester at a time, drives the memory bus and returns registered read data with a one-cycle acknowledge. Data accesses have priority. An optional fairness limit bounds how long fetch can be starved. It sits between `IF_stage`/`MEM_stage` and the external memory. Pipeline stall logic treats a pending request without `*_ack` as a stall source.

---
 rtl/lapido_mem_arbiter_pkg.sv | 19 +
 rtl/lapido_mem_arbiter_streak_counter.sv | 40 ++++
 rtl/lapido_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_lapido_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lapido_mem_arbiter_pkg.sv
// Shared types and helpers for the lapido fetch/data memory arbiter.
// Holds the arbiter state encoding and the streak-counter width and saturation helper.
package lapido_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam int STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_SAT = 4'd15;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] value);
    return (value == STREAK_SAT) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/lapido_mem_arbiter_streak_counter.sv
// Counts data grants that overtook a waiting fetch and blocks the data port once
// MAX_DATA_STREAK of them have occurred in a row. Used only in LAPIDO_ARB_FAIR_EN builds.
module lapido_arb_streak_counter
  import lapido_mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic fetch_pending,
  output logic block
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] count_r;

  // Streak tracking: a fetch grant or an uncontested data grant ends the streak.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= '0;
    end else if (fetch_grant) begin
      count_r <= '0;
    end else if (data_grant) begin
      if (fetch_pending) begin
        count_r <= streak_inc(count_r);
      end else begin
        count_r <= '0;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Blocking only matters while a fetch is waiting, so data can never be locked out alone.
  assign block = (count_r == STREAK_LIMIT) && fetch_pending;

endmodule

// File: rtl/lapido_mem_arbiter.sv
// Fetch/data arbiter for one shared variable-latency memory; data has priority.
// Optional fetch fairness limit is enabled by defining LAPIDO_ARB_FAIR_EN.
module lapido_mem_arbiter
  import lapido_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  arb_state_t            state_r;
  arb_state_t            state_next;
  logic                  grant_data_s;
  logic                  grant_fetch_s;
  logic                  data_blocked_s;
  logic                  data_sel_r;
  logic                  we_lat_r;
  logic                  mem_req_next_s;
  logic                  mem_we_next_s;
  logic                  if_ack_next_s;
  logic                  dm_ack_next_s;
  logic                  mem_req_r;
  logic                  mem_we_r;
  logic                  if_ack_r;
  logic                  dm_ack_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [DATA_WIDTH-1:0] if_rdata_r;
  logic [DATA_WIDTH-1:0] dm_rdata_r;

`ifdef LAPIDO_ARB_FAIR_EN
  lapido_arb_streak_counter #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk          (clk),
    .rst          (rst),
    .data_grant   (grant_data_s),
    .fetch_grant  (grant_fetch_s),
    .fetch_pending(if_req),
    .block        (data_blocked_s)
  );
`else
  // Unlimited build: only a degenerate zero limit (fetch always first) can hold data off.
  assign data_blocked_s = (MAX_DATA_STREAK == 0) && if_req;
`endif

  // Grant decision, taken only from IDLE.
  always_comb begin
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    if (state_r == ARB_IDLE) begin
      if (dm_req && !data_blocked_s) begin
        grant_data_s = 1'b1;
      end else if (if_req) begin
        grant_fetch_s = 1'b1;
      end else begin
        grant_data_s  = 1'b0;
        grant_fetch_s = 1'b0;
      end
    end else begin
      grant_data_s  = 1'b0;
      grant_fetch_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (grant_data_s) begin
          state_next = ARB_DATA;
        end else if (grant_fetch_s) begin
          state_next = ARB_FETCH;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_FETCH, ARB_DATA: begin
        if (mem_ready) begin
          state_next = ARB_RESP;
        end else begin
          state_next = state_r;
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Output decode from the next state, so every output leaves a flop.
  always_comb begin
    mem_req_next_s = (state_next == ARB_FETCH) || (state_next == ARB_DATA);
    mem_we_next_s  = 1'b0;
    if_ack_next_s  = 1'b0;
    dm_ack_next_s  = 1'b0;
    if (state_next == ARB_DATA) begin
      mem_we_next_s = grant_data_s ? dm_we : we_lat_r;
    end else if (state_next == ARB_RESP) begin
      if_ack_next_s = !data_sel_r;
      dm_ack_next_s = data_sel_r;
    end else begin
      mem_we_next_s = 1'b0;
    end
  end

  // Control output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
      if_ack_r  <= 1'b0;
      dm_ack_r  <= 1'b0;
    end else begin
      mem_req_r <= mem_req_next_s;
      mem_we_r  <= mem_we_next_s;
      if_ack_r  <= if_ack_next_s;
      dm_ack_r  <= dm_ack_next_s;
    end
  end

  // Bus latch at grant and read-data capture on completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_sel_r  <= 1'b0;
      we_lat_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      dm_rdata_r  <= '0;
    end else begin
      if (grant_data_s) begin
        data_sel_r  <= 1'b1;
        we_lat_r    <= dm_we;
        mem_addr_r  <= dm_addr;
        mem_wdata_r <= dm_wdata;
      end else if (grant_fetch_s) begin
        data_sel_r <= 1'b0;
        we_lat_r   <= 1'b0;
        mem_addr_r <= if_addr;
      end else begin
        data_sel_r <= data_sel_r;
        we_lat_r   <= we_lat_r;
      end
      if ((state_r == ARB_FETCH) && mem_ready) begin
        if_rdata_r <= mem_rdata;
      end else begin
        if_rdata_r <= if_rdata_r;
      end
      if ((state_r == ARB_DATA) && mem_ready && !we_lat_r) begin
        dm_rdata_r <= mem_rdata;
      end else begin
        dm_rdata_r <= dm_rdata_r;
      end
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_ack    = if_ack_r;
  assign dm_ack    = dm_ack_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;

endmodule

// File: tb/tb_lapido_mem_arbiter.sv
// Directed bench for lapido_mem_arbiter: transaction-level reference model checked every
// cycle, plus hand-computed expectations per scenario. Honours LAPIDO_ARB_FAIR_EN.
module tb_lapido_mem_arbiter;

`ifdef LAPIDO_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  int          n_assert = 0;
  int          n_fail = 0;
  int          ws = 0;
  logic [31:0] rd_val = 32'h0;

  lapido_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: completes an access after ws wait cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ready = (wcnt >= ws);
        wcnt++;
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
      mem_rdata = mem_ready ? rd_val : 32'hBAD0_0BAD;
    end
  end

  // Reference model: one outstanding transaction, phase 0 = free, 1 = on the bus, 2 = acking.
  bit          m_valid = 1'b0;
  int          m_phase = 0;
  bit          m_data = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_dm_rdata = 32'h0;
  int          m_streak = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1'b1;
      m_phase = 0;
      m_data = 1'b0;
      m_we = 1'b0;
      m_addr = 32'h0;
      m_wdata = 32'h0;
      m_if_rdata = 32'h0;
      m_dm_rdata = 32'h0;
      m_streak = 0;
    end else if (m_phase == 0) begin
      if (dm_req && !(FAIR && m_streak == MAXS && if_req)) begin
        m_phase = 1; m_data = 1'b1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        m_streak = if_req ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
      end else if (if_req) begin
        m_phase = 1; m_data = 1'b0; m_we = 1'b0; m_addr = if_addr; m_streak = 0;
      end
    end else if (m_phase == 1) begin
      if (mem_ready) begin
        m_phase = 2;
        if (!m_data) m_if_rdata = mem_rdata;
        else if (!m_we) m_dm_rdata = mem_rdata;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("mdl_mem_req", {31'h0, mem_req}, {31'h0, m_phase == 1});
      check("mdl_mem_we", {31'h0, mem_we}, {31'h0, (m_phase == 1) && m_data && m_we});
      check("mdl_if_ack", {31'h0, if_ack}, {31'h0, (m_phase == 2) && !m_data});
      check("mdl_dm_ack", {31'h0, dm_ack}, {31'h0, (m_phase == 2) && m_data});
      check("mdl_if_rdata", if_rdata, m_if_rdata);
      check("mdl_dm_rdata", dm_rdata, m_dm_rdata);
      if (m_phase == 1) check("mdl_mem_addr", mem_addr, m_addr);
      if (m_phase == 1 && m_data && m_we) check("mdl_mem_wdata", mem_wdata, m_wdata);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit order_is_data[6];
    int n_acks;
    int n_fetch;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata", if_rdata | dm_rdata, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // Single fetch, zero wait states.
    if_req = 1'b1; if_addr = 32'h10; rd_val = 32'hDEADBEEF; ws = 0;
    @(negedge clk);
    check("t1_c0_idle", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    check("t1_mem_req", {31'h0, mem_req}, 32'h1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check("t1_if_ack", {31'h0, if_ack}, 32'h1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    check("t1_ack_one_cycle", {31'h0, if_ack}, 32'h0);

    // Collision: data first, then fetch.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    rd_val = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    check("t2_data_first", mem_addr, 32'h40);
    @(negedge clk);
    check("t2_dm_ack", {30'h0, dm_ack, if_ack}, 32'h2);
    check("t2_dm_rdata", dm_rdata, 32'h11111111);
    @(posedge clk); #1; dm_req = 1'b0; rd_val = 32'h22222222;
    @(negedge clk);
    check("t2_dm_ack_one_cycle", {31'h0, dm_ack}, 32'h0);
    @(negedge clk);
    check("t2_fetch_addr", mem_addr, 32'h20);
    @(negedge clk);
    check("t2_if_ack", {30'h0, dm_ack, if_ack}, 32'h1);
    check("t2_if_rdata", if_rdata, 32'h22222222);
    @(posedge clk); #1; if_req = 1'b0;
    @(negedge clk);
    check("t2_if_ack_one_cycle", {31'h0, if_ack}, 32'h0);

    // Data write with 3 wait states.
    @(posedge clk); #1;
    ws = 3; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_bus", {mem_req, mem_we, dm_ack, 29'h0}, {1'b1, 1'b1, 1'b0, 29'h0});
      check("t3_addr", mem_addr, 32'h80);
      check("t3_wdata", mem_wdata, 32'h1234);
    end
    @(negedge clk);
    check("t3_dm_ack", {31'h0, dm_ack}, 32'h1);
    check("t3_rdata_kept", dm_rdata, 32'h11111111);
    @(posedge clk); #1; dm_req = 1'b0; dm_we = 1'b0;

    // Address change after grant is ignored.
    @(posedge clk); #1;
    ws = 2; rd_val = 32'h33333333; dm_req = 1'b1; dm_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    check("t4_addr_c1", mem_addr, 32'h40);
    @(posedge clk); #1; dm_addr = 32'h44;
    @(negedge clk);
    check("t4_addr_c2", mem_addr, 32'h40);
    @(negedge clk);
    check("t4_addr_c3", mem_addr, 32'h40);
    @(negedge clk);
    check("t4_dm_ack", {31'h0, dm_ack}, 32'h1);
    check("t4_dm_rdata", dm_rdata, 32'h33333333);
    @(posedge clk); #1; dm_req = 1'b0;

    // Starvation: both requesters renew continuously.
    @(posedge clk); #1;
    ws = 0; rd_val = 32'h44444444;
    if_addr = 32'h100; dm_we = 1'b0; dm_addr = 32'h200; if_req = 1'b1; dm_req = 1'b1;
    n_acks = 0; n_fetch = 0;
    for (int c = 0; c < 24 && n_acks < 6; c++) begin
      @(negedge clk);
      if (dm_ack || if_ack) begin
        order_is_data[n_acks] = dm_ack;
        if (if_ack) n_fetch++;
        n_acks++;
      end
    end
    @(posedge clk); #1; if_req = 1'b0; dm_req = 1'b0;
    check("t5_ack_count", n_acks, 32'd6);
    check("t5_fetch_grants", n_fetch, FAIR ? 32'd1 : 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("t5_order", {31'h0, order_is_data[i]}, {31'h0, !(FAIR && i == 4)});
    end

    // Reset in the middle of a data access.
    @(posedge clk); #1;
    ws = 5; rd_val = 32'h55555555; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy", mem_addr, 32'h300);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; ws = 0;
    @(negedge clk);
    check("t6_rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("t6_rst_acks", {30'h0, if_ack, dm_ack}, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("t6_idle", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    check("t6_regrant", {mem_req, 31'h0}, 32'h8000_0000);
    check("t6_regrant_addr", mem_addr, 32'h300);
    @(negedge clk);
    check("t6_dm_ack", {31'h0, dm_ack}, 32'h1);
    check("t6_dm_rdata", dm_rdata, 32'h55555555);
    @(posedge clk); #1; dm_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
